uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART 8N1 transmitter fed by a byte FIFO
// Define UART_TX_PARITY_EN to add an even-parity bit between data[7] and the stop bit.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       ready,
  output logic       tx,
  output logic       busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CLK   = CW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop;
  logic [7:0]    head;

  state_t        state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  assign ready   = (count != FULL_COUNT);
  assign busy    = (state != IDLE) || (count != '0);
  assign push    = rst_n && data_valid && ready;
  assign head    = mem[rd_ptr];
  assign bit_end = (clk_cnt == LAST_CLK);

  // Pop only when the shift register is free: from IDLE, or as STOP completes.
  always_comb begin
    pop = 1'b0;
    if (count != '0) begin
      if (state == IDLE)
        pop = 1'b1;
      else if (state == STOP && bit_end)
        pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // tx follows the state one cycle later, so every bit keeps its full width.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    tx <= 1'b1;
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
`ifdef UART_TX_PARITY_EN
        PARITY:  tx <= parity;
`endif
        default: tx <= 1'b1;
      endcase

      if (state != IDLE)
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;

      if (pop) begin
        shift   <= head;
        bit_idx <= '0;
        clk_cnt <= '0;
        state   <= START;
`ifdef UART_TX_PARITY_EN
        parity  <= ^head;
`endif
      end else if (bit_end) begin
        case (state)
          START: state <= DATA;
          DATA: begin
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: state <= STOP;
`endif
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data = 8'h00;
  logic       data_valid = 1'b0;
  logic       ready, tx, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_abort = 1'b0;
  logic [7:0] rxq[$];
  int start_q[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid),
    .ready(ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offers b (data_valid left high) and returns how many cycles it stalled.
  task automatic push_byte(input logic [7:0] b, output int n);
    data = b;
    data_valid = 1'b1;
    n = 0;
    while (!ready && n < 400) begin
      tick();
      n++;
    end
    check("push_ready", ready, 1);
    tick();
  endtask

  task automatic wait_rx(input int cnt);
    int n = 0;
    while (rxq.size() < cnt && n < 2000) begin
      tick();
      n++;
    end
    check("rx_count", rxq.size(), cnt);
  endtask

  // Serial receiver: samples each bit mid-cell at negedges.
  initial begin
    logic [7:0] b;
    logic       p;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        start_q.push_back(cyc);
        b = 8'h00;
        p = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        if (NB == 11) begin
          repeat (CPB) @(negedge clk);
          p = tx;
        end
        repeat (CPB) @(negedge clk);
        if (!mon_abort) begin
          check("rx_stop", tx, 1);
          if (NB == 11) check("rx_parity", p, ^b);
          rxq.push_back(b);
        end
      end
    end
  end

  initial begin
    logic [10:0] fr;
    int n;
    int lows;
    logic [7:0] exp_b;

    tick();
    tick();
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Single byte 0x35: start, 1,0,1,0,1,1,0,0, [parity 0], stop
    fr = (NB == 11) ? 11'b10_0011_0101_0 : 11'b11_0011_0101_0;
    data = 8'h35;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check("e0_tx", tx, 1);
    check("e0_busy", busy, 1);
    tick();
    check("e1_tx", tx, 1);
    for (int k = 0; k < NB; k++) begin
      for (int c = 0; c < CPB; c++) begin
        tick();
        if (c == 0 || c == CPB - 1) check($sformatf("bit%0d_c%0d", k, c), tx, fr[k]);
        if (k == NB - 1 && c == CPB - 2) check("busy_in_stop", busy, 1);
        if (k == NB - 1 && c == CPB - 1) check("busy_after_stop", busy, 0);
      end
    end
    tick();
    check("idle_tx", tx, 1);
    wait_rx(1);
    check("rx_35", rxq.pop_front(), 8'h35);

    // Burst 0x01..0x05 then 0x06 offered against a full FIFO
    start_q.delete();
    for (int i = 1; i <= 5; i++) push_byte(8'(i), n);
    check("burst_full", ready, 0);
    check("burst_busy", busy, 1);
    push_byte(8'h06, n);
    data_valid = 1'b0;
    check("stall_cycles", n, 4 * NB - 3);
    wait_rx(6);
    for (int i = 0; i < 6 && rxq.size() > 0; i++) check("burst_order", rxq.pop_front(), 8'(i + 1));
    for (int i = 0; i + 1 < start_q.size(); i++) check("burst_gap", start_q[i + 1] - start_q[i], 4 * NB);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check("burst_done_busy", busy, 0);
    check("burst_done_ready", ready, 1);

    // Reset during data bit 3 with two bytes queued
    mon_abort = 1'b1;
    push_byte(8'hAA, n);
    push_byte(8'hBB, n);
    push_byte(8'hCC, n);
    data_valid = 1'b0;
    repeat (17) tick();
    check("pre_rst_bit3", tx, 1);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    data = 8'h55;
    data_valid = 1'b1;
    tick();
    check("mid_rst_tx", tx, 1);
    check("mid_rst_ready", ready, 1);
    check("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    data_valid = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);
    lows = 0;
    repeat (60) begin
      tick();
      if (!tx) lows++;
    end
    check("no_tx_after_rst", lows, 0);
    check("post_rst_idle", busy, 0);
    mon_abort = 1'b0;
    rxq.delete();
    start_q.delete();

    // Eight bytes through a four-deep FIFO: pointers wrap twice
    for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i), n);
    data_valid = 1'b0;
    wait_rx(8);
    for (int i = 0; i < 8 && rxq.size() > 0; i++) begin
      exp_b = 8'hA0 + 8'(i);
      check("wrap_order", rxq.pop_front(), exp_b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
